// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: autonomous bus master that drives i2c_master_top.
// Each single-byte register request becomes a prescaler/control init (once
// after reset), then TXR/CR writes, SR polling and RXR readback. Exactly one
// response is returned per request.
// Optional build macro I2C_SEQ_TIMEOUT_EN bounds every SR wait to POLL_MAX
// polls. Without it, polling is unbounded.
`timescale 1ns/1ps
module i2c_txn_sequencer #(
  parameter int unsigned DWIDTH   = 32'd8,
  parameter int unsigned AWIDTH   = 32'd3,
  parameter logic [7:0]  PRESCALE = 8'h07,
  parameter logic [15:0] POLL_MAX = 16'd4095
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqRead,
  input  logic [6:0]        ReqSlvAddr,
  input  logic [7:0]        ReqMemAddr,
  input  logic [7:0]        ReqWrData,
  output logic              RspValid,
  output logic [7:0]        RspData,
  output logic              RspErr,
  output logic              Busy,
  output logic [AWIDTH-1:0] Addr,
  output logic [DWIDTH-1:0] Dout,
  input  logic [DWIDTH-1:0] Din,
  output logic              Wr
);

  // i2c_master_top register map (TXR/RXR and CR/SR share addresses)
  localparam logic [AWIDTH-1:0] ADR_PRER = AWIDTH'(32'd0);
  localparam logic [AWIDTH-1:0] ADR_CTR  = AWIDTH'(32'd2);
  localparam logic [AWIDTH-1:0] ADR_TXR  = AWIDTH'(32'd3);
  localparam logic [AWIDTH-1:0] ADR_RXR  = AWIDTH'(32'd3);
  localparam logic [AWIDTH-1:0] ADR_CR   = AWIDTH'(32'd4);
  localparam logic [AWIDTH-1:0] ADR_SR   = AWIDTH'(32'd4);

  localparam logic [7:0] CR_STA  = 8'h80;
  localparam logic [7:0] CR_STO  = 8'h40;
  localparam logic [7:0] CR_RD   = 8'h20;
  localparam logic [7:0] CR_WR   = 8'h10;
  localparam logic [7:0] CR_NACK = 8'h08;
  localparam logic [7:0] CTR_EN  = 8'h80;

  // Reject configurations the datapath cannot support
  if (DWIDTH != 32'd8 || POLL_MAX == 16'd0) begin : g_param_check
    $error("i2c_txn_sequencer: DWIDTH must be 8 and POLL_MAX nonzero");
  end

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT_PRER = 4'd1,
    S_INIT_CTR  = 4'd2,
    S_STEP_TXR  = 4'd3,
    S_STEP_CR   = 4'd4,
    S_POLL_ADDR = 4'd5,
    S_POLL_CHK  = 4'd6,
    S_RX_ADDR   = 4'd7,
    S_RX_CAPT   = 4'd8,
    S_ABORT_CR  = 4'd9,
    S_DONE      = 4'd10
  } state_t;

  state_t            state_q, state_d;
  logic              init_done_q, init_done_d;
  logic              read_q, read_d;
  logic [6:0]        slv_q, slv_d;
  logic [7:0]        mem_q, mem_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [1:0]        step_q, step_d;
  logic              abort_q, abort_d;   // waiting for bus release after STOP
  logic              err_q, err_d;
  logic [7:0]        rx_q, rx_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [15:0]       poll_cnt_q, poll_cnt_d;
`endif

  logic sr_tip_s, sr_busy_s, sr_al_s, sr_rxack_s;
  logic final_step_s, ack_checked_s, repoll_s;

  // TXR payload for a programme step
  function automatic logic [7:0] txr_byte(input logic rd, input logic [1:0] step,
                                          input logic [6:0] slv, input logic [7:0] mem,
                                          input logic [7:0] wd);
    logic [7:0] b;
    case (step)
      2'd0:    b = {slv, 1'b0};
      2'd1:    b = mem;
      2'd2:    b = rd ? {slv, 1'b1} : wd;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // CR command for a programme step
  function automatic logic [7:0] cr_byte(input logic rd, input logic [1:0] step);
    logic [7:0] b;
    case (step)
      2'd0:    b = CR_STA | CR_WR;
      2'd1:    b = CR_WR;
      2'd2:    b = rd ? (CR_STA | CR_WR) : (CR_STO | CR_WR);
      2'd3:    b = CR_RD | CR_STO | CR_NACK;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign sr_tip_s      = Din[1];
  assign sr_al_s       = Din[5];
  assign sr_busy_s     = Din[6];
  assign sr_rxack_s    = Din[7];
  // The last read step NACKs its own byte, so RxACK is meaningless there
  assign ack_checked_s = !(read_q && step_q == 2'd3);
  assign final_step_s  = read_q ? (step_q == 2'd3) : (step_q == 2'd2);

  // Next-state logic: sequencing, request latch, SR evaluation
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    read_d      = read_q;
    slv_d       = slv_q;
    mem_d       = mem_q;
    wdata_d     = wdata_q;
    step_d      = step_q;
    abort_d     = abort_q;
    err_d       = err_q;
    rx_d        = rx_q;
    repoll_s    = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
    poll_cnt_d  = poll_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ReqValid) begin
          read_d  = ReqRead;
          slv_d   = ReqSlvAddr;
          mem_d   = ReqMemAddr;
          wdata_d = ReqWrData;
          step_d  = 2'd0;
          abort_d = 1'b0;
          err_d   = 1'b0;
          rx_d    = 8'h00;
          state_d = init_done_q ? S_STEP_TXR : S_INIT_PRER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT_PRER: state_d = S_INIT_CTR;
      S_INIT_CTR: begin
        init_done_d = 1'b1;
        state_d     = S_STEP_TXR;
      end
      S_STEP_TXR: state_d = S_STEP_CR;
      S_STEP_CR: begin
`ifdef I2C_SEQ_TIMEOUT_EN
        poll_cnt_d = 16'd0;
`endif
        state_d = S_POLL_ADDR;
      end
      S_POLL_ADDR: state_d = S_POLL_CHK;
      S_POLL_CHK: begin
        if (abort_q) begin
          if (!sr_tip_s && !sr_busy_s) begin
            state_d = S_DONE;
          end else begin
            repoll_s = 1'b1;
          end
        end else if (sr_al_s) begin
          err_d   = 1'b1;
          state_d = sr_busy_s ? S_ABORT_CR : S_DONE;
        end else if (sr_tip_s) begin
          repoll_s = 1'b1;
        end else if (ack_checked_s && sr_rxack_s) begin
          err_d   = 1'b1;
          state_d = S_ABORT_CR;
        end else if (final_step_s) begin
          if (sr_busy_s) begin
            repoll_s = 1'b1;
          end else begin
            state_d = read_q ? S_RX_ADDR : S_DONE;
          end
        end else begin
          step_d  = step_q + 2'd1;
          // Read step 3 only issues a command, there is nothing to transmit
          state_d = (read_q && step_q == 2'd2) ? S_STEP_CR : S_STEP_TXR;
        end
      end
      S_RX_ADDR: state_d = S_RX_CAPT;
      S_RX_CAPT: begin
        rx_d    = Din;
        state_d = S_DONE;
      end
      S_ABORT_CR: begin
        abort_d = 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
        poll_cnt_d = 16'd0;
`endif
        state_d = S_POLL_ADDR;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (repoll_s) begin
`ifdef I2C_SEQ_TIMEOUT_EN
      if (poll_cnt_q >= POLL_MAX - 16'd1) begin
        err_d   = 1'b1;
        state_d = abort_q ? S_DONE : S_ABORT_CR;
      end else begin
        poll_cnt_d = poll_cnt_q + 16'd1;
        state_d    = S_POLL_ADDR;
      end
`else
      state_d = S_POLL_ADDR;
`endif
    end else begin
      state_d = state_d;
    end
  end

  // Output decode from the next state so bus and response outputs are registered
  always_comb begin
    addr_d      = addr_q;
    dout_d      = dout_q;
    wr_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = (state_d != S_IDLE);
    case (state_d)
      S_INIT_PRER: begin
        addr_d = ADR_PRER;
        dout_d = DWIDTH'(PRESCALE);
        wr_d   = 1'b1;
      end
      S_INIT_CTR: begin
        addr_d = ADR_CTR;
        dout_d = DWIDTH'(CTR_EN);
        wr_d   = 1'b1;
      end
      S_STEP_TXR: begin
        addr_d = ADR_TXR;
        dout_d = DWIDTH'(txr_byte(read_d, step_d, slv_d, mem_d, wdata_d));
        wr_d   = 1'b1;
      end
      S_STEP_CR: begin
        addr_d = ADR_CR;
        dout_d = DWIDTH'(cr_byte(read_d, step_d));
        wr_d   = 1'b1;
      end
      S_ABORT_CR: begin
        addr_d = ADR_CR;
        dout_d = DWIDTH'(CR_STO);
        wr_d   = 1'b1;
      end
      S_POLL_ADDR: addr_d = ADR_SR;
      S_RX_ADDR:   addr_d = ADR_RXR;
      S_DONE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = rx_d;
        rsp_err_d   = err_d;
      end
      default: addr_d = addr_q;
    endcase
  end

  // State, latched request and registered outputs; Rst wins even mid-transaction
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      init_done_q <= 1'b0;
      read_q      <= 1'b0;
      slv_q       <= 7'h00;
      mem_q       <= 8'h00;
      wdata_q     <= 8'h00;
      step_q      <= 2'd0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      rx_q        <= 8'h00;
      addr_q      <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
      poll_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      read_q      <= read_d;
      slv_q       <= slv_d;
      mem_q       <= mem_d;
      wdata_q     <= wdata_d;
      step_q      <= step_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
      rx_q        <= rx_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
`ifdef I2C_SEQ_TIMEOUT_EN
      poll_cnt_q  <= poll_cnt_d;
`endif
    end
  end

  assign ReqReady = (state_q == S_IDLE);
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign RspErr   = rsp_err_q;
  assign Busy     = busy_q;
  assign Addr     = addr_q;
  assign Dout     = dout_q;
  assign Wr       = wr_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: bus-level model of i2c_master_top plus a
// 16-byte I2C slave at 0x10. Table-driven request vectors followed by
// hand-written corner-case sequences.
`timescale 1ns/1ps
module tb_i2c_txn_sequencer;

  localparam logic [6:0] SLV  = 7'h10;
  localparam int         XFER = 20;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       ReqValid = 1'b0, ReqReady, ReqRead = 1'b0;
  logic [6:0] ReqSlvAddr = 7'h00;
  logic [7:0] ReqMemAddr = 8'h00, ReqWrData = 8'h00;
  logic       RspValid, RspErr, Busy, Wr;
  logic [7:0] RspData, Dout, Din;
  logic [2:0] Addr;

  i2c_txn_sequencer dut (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqRead(ReqRead), .ReqSlvAddr(ReqSlvAddr), .ReqMemAddr(ReqMemAddr),
    .ReqWrData(ReqWrData), .RspValid(RspValid), .RspData(RspData),
    .RspErr(RspErr), .Busy(Busy), .Addr(Addr), .Dout(Dout), .Din(Din), .Wr(Wr)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- i2c_master_top + slave model ----------------
  logic [7:0] mem [0:15];
  bit         mem_inited;
  logic       m_tip, m_busy, m_al, m_rxack;
  int         m_tcnt, m_bcnt, m_phase;
  logic [7:0] m_prer, m_ctr, m_txr, m_cr, m_rxr;
  logic [3:0] m_ptr;
  int         stretch_cyc = 0;
  bit         force_al = 1'b0;

  always @(posedge Clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      mem_inited <= 1'b1;
    end
    if (Rst) begin
      m_tip <= 1'b0; m_busy <= 1'b0; m_al <= 1'b0; m_rxack <= 1'b0;
      m_tcnt <= 0; m_bcnt <= 0; m_phase <= 0; m_ptr <= 4'd0;
      m_prer <= 8'h00; m_ctr <= 8'h00; m_txr <= 8'h00; m_cr <= 8'h00;
      m_rxr <= 8'h00; Din <= 8'h00;
    end else begin
      Din <= (Addr == 3'd4) ? {m_rxack, m_busy, m_al, 3'b000, m_tip, 1'b0} :
             (Addr == 3'd3) ? m_rxr : 8'h00;
      if (m_bcnt != 0) begin
        m_bcnt <= m_bcnt - 1;
        if (m_bcnt == 1) m_busy <= 1'b0;
      end
      if (m_tip) begin
        if (m_tcnt != 0) m_tcnt <= m_tcnt - 1;
        else begin
          m_tip <= 1'b0;
          if (m_cr[4]) begin
            if (m_cr[7]) begin
              if (m_txr[7:1] == SLV) begin
                m_rxack <= 1'b0; m_phase <= m_txr[0] ? 3 : 1;
              end else begin
                m_rxack <= 1'b1; m_phase <= 0;
              end
            end else if (m_phase == 1) begin
              if (m_txr < 8'h10) begin
                m_rxack <= 1'b0; m_ptr <= m_txr[3:0]; m_phase <= 2;
              end else begin
                m_rxack <= 1'b1; m_phase <= 0;
              end
            end else if (m_phase == 2) begin
              mem[m_ptr] <= m_txr; m_ptr <= m_ptr + 4'd1; m_rxack <= 1'b0;
            end else m_rxack <= 1'b1;
          end
          if (m_cr[5]) begin
            m_rxr <= mem[m_ptr]; m_ptr <= m_ptr + 4'd1; m_rxack <= m_cr[3];
          end
          if (m_cr[6]) m_bcnt <= 3;
          if (force_al) begin
            m_al <= 1'b1; m_busy <= 1'b0; m_phase <= 0;
          end
        end
      end
      if (Wr) begin
        case (Addr)
          3'd0: m_prer <= Dout;
          3'd2: m_ctr <= Dout;
          3'd3: m_txr <= Dout;
          3'd4: begin
            m_cr <= Dout; m_tip <= 1'b1; m_al <= 1'b0;
            m_tcnt <= XFER + ((Dout == 8'h50) ? stretch_cyc : 0);
            if (Dout[7]) m_busy <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Bus write log and response counter
  logic [10:0] wr_log [$];
  int rsp_cnt = 0;
  always @(posedge Clk) begin
    if (!Rst && Wr) wr_log.push_back({Addr, Dout});
    if (RspValid) rsp_cnt <= rsp_cnt + 1;
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic rd; logic [6:0] slv; logic [7:0] mem; logic [7:0] wd;
    logic [7:0] exp_data; logic exp_err; logic [39:0] exp_cr;
    int exp_ncr; int exp_txr; int exp_init;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag, output int lat);
    bit acc, got;
    logic [39:0] p;
    int ncr, ntxr, ninit;
    wr_log.delete();
    ReqRead = v.rd; ReqSlvAddr = v.slv; ReqMemAddr = v.mem; ReqWrData = v.wd;
    ReqValid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      if (ReqReady) acc = 1'b1;
      @(negedge Clk);
    end
    ReqValid = 1'b0;
    chk({tag, ".accepted"}, {63'd0, acc}, 64'd1);
    chk({tag, ".busy_after_accept"}, {63'd0, Busy}, 64'd1);
    chk({tag, ".ready_after_accept"}, {63'd0, ReqReady}, 64'd0);
    got = 1'b0; lat = 0;
    for (int n = 0; n < 4000 && !got; n++) begin
      if (RspValid) got = 1'b1;
      else begin
        @(negedge Clk);
        lat++;
      end
    end
    chk({tag, ".rsp_seen"}, {63'd0, got}, 64'd1);
    chk({tag, ".rsp_data"}, {56'd0, RspData}, {56'd0, v.exp_data});
    chk({tag, ".rsp_err"}, {63'd0, RspErr}, {63'd0, v.exp_err});
    p = 40'd0; ncr = 0; ntxr = 0; ninit = 0;
    foreach (wr_log[i]) begin
      if (wr_log[i][10:8] == 3'd4) begin
        p = {p[31:0], wr_log[i][7:0]}; ncr++;
      end else if (wr_log[i][10:8] == 3'd3) ntxr++;
      else ninit++;
    end
    chk({tag, ".cr_seq"}, {24'd0, p}, {24'd0, v.exp_cr});
    chk({tag, ".cr_count"}, 64'(ncr), 64'(v.exp_ncr));
    chk({tag, ".txr_count"}, 64'(ntxr), 64'(v.exp_txr));
    chk({tag, ".init_writes"}, 64'(ninit), 64'(v.exp_init));
    @(negedge Clk);
    chk({tag, ".rsp_one_cycle"}, {63'd0, RspValid}, 64'd0);
    chk({tag, ".busy_clear"}, {63'd0, Busy}, 64'd0);
    chk({tag, ".rsp_data_hold"}, {56'd0, RspData}, {56'd0, v.exp_data});
  endtask

  vec_t vecs [7];
  vec_t v;
  int   lat, base_lat, rsp_base;
  bit   got, seen;

  initial begin
    //          rd    slv     mem     wd     data   err   cr sequence      ncr txr init
    vecs[0] = '{1'b0, 7'h10, 8'h01, 8'hA5, 8'h00, 1'b0, 40'h0000901050, 3, 3, 2};
    vecs[1] = '{1'b0, 7'h10, 8'h02, 8'h5A, 8'h00, 1'b0, 40'h0000901050, 3, 3, 0};
    vecs[2] = '{1'b1, 7'h10, 8'h01, 8'h00, 8'hA5, 1'b0, 40'h0090109068, 4, 3, 0};
    vecs[3] = '{1'b0, 7'h10, 8'h10, 8'h33, 8'h00, 1'b1, 40'h0000901040, 3, 2, 0};
    vecs[4] = '{1'b0, 7'h22, 8'h03, 8'h44, 8'h00, 1'b1, 40'h0000009040, 2, 1, 0};
    vecs[5] = '{1'b0, 7'h10, 8'h0F, 8'hC3, 8'h00, 1'b0, 40'h0000901050, 3, 3, 0};
    vecs[6] = '{1'b1, 7'h10, 8'h0F, 8'h00, 8'hC3, 1'b0, 40'h0090109068, 4, 3, 0};
    base_lat = 0;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("reset.ReqReady", {63'd0, ReqReady}, 64'd1);
    chk("reset.RspValid", {63'd0, RspValid}, 64'd0);
    chk("reset.Busy", {63'd0, Busy}, 64'd0);
    chk("reset.Wr", {63'd0, Wr}, 64'd0);
    chk("reset.Addr_Dout", {53'd0, Addr, Dout}, 64'd0);
    Rst = 1'b0;
    @(negedge Clk);

    // Table-driven requests
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), lat);
      if (i == 1) base_lat = lat;
    end
    chk("model.prer", {56'd0, m_prer}, 64'h07);
    chk("model.ctr", {56'd0, m_ctr}, 64'h80);
    chk("mem1", {56'd0, mem[1]}, 64'hA5);
    chk("mem2", {56'd0, mem[2]}, 64'h5A);
    chk("mem3_untouched", {56'd0, mem[3]}, 64'h00);
    chk("mem15", {56'd0, mem[15]}, 64'hC3);

    // SCL held low for 1100 ns on the data byte
    stretch_cyc = 110;
    v = '{1'b0, 7'h10, 8'h04, 8'h96, 8'h00, 1'b0, 40'h0000901050, 3, 3, 0};
    run_vec(v, "stretch", lat);
    stretch_cyc = 0;
    chk("stretch.mem4", {56'd0, mem[4]}, 64'h96);
    chk("stretch.extended", {63'd0, lat >= base_lat + 100}, 64'd1);

    // Arbitration lost with the bus already free: no STOP is issued
    force_al = 1'b1;
    v = '{1'b0, 7'h10, 8'h05, 8'h77, 8'h00, 1'b1, 40'h0000000090, 1, 1, 0};
    run_vec(v, "arb_lost", lat);
    force_al = 1'b0;
    chk("arb_lost.mem5", {56'd0, mem[5]}, 64'h00);

    // ReqValid held through the whole transaction and into the next IDLE
    rsp_base = rsp_cnt;
    ReqRead = 1'b1; ReqSlvAddr = SLV; ReqMemAddr = 8'h02; ReqValid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 4000 && !got; n++) begin
      @(negedge Clk);
      if (RspValid) got = 1'b1;
    end
    chk("held.rsp_seen", {63'd0, got}, 64'd1);
    chk("held.rsp_data", {56'd0, RspData}, 64'h5A);
    chk("held.rsp_err", {63'd0, RspErr}, 64'd0);
    ReqMemAddr = 8'h01;
    @(negedge Clk);
    chk("held.ready_in_idle", {63'd0, ReqReady}, 64'd1);
    @(negedge Clk);
    chk("held.second_accepted", {62'd0, Busy, ReqReady}, 64'd2);
    ReqValid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 4000 && !got; n++) begin
      @(negedge Clk);
      if (RspValid) got = 1'b1;
    end
    chk("held.second_rsp_data", {56'd0, RspData}, 64'hA5);
    repeat (40) @(negedge Clk);
    chk("held.rsp_count", 64'(rsp_cnt - rsp_base), 64'd2);

    // Reset in the middle of an SR poll
    ReqRead = 1'b0; ReqSlvAddr = SLV; ReqMemAddr = 8'h06; ReqWrData = 8'h99;
    ReqValid = 1'b1;
    @(negedge Clk);
    ReqValid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge Clk);
      if (Addr == 3'd4 && !Wr && Busy) seen = 1'b1;
    end
    chk("rst_mid.poll_seen", {63'd0, seen}, 64'd1);
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst_mid.ReqReady", {63'd0, ReqReady}, 64'd1);
    chk("rst_mid.RspValid_Err", {62'd0, RspValid, RspErr}, 64'd0);
    chk("rst_mid.RspData", {56'd0, RspData}, 64'd0);
    chk("rst_mid.Busy_Wr", {62'd0, Busy, Wr}, 64'd0);
    chk("rst_mid.Addr_Dout", {53'd0, Addr, Dout}, 64'd0);
    Rst = 1'b0;
    @(negedge Clk);
    v = '{1'b0, 7'h10, 8'h07, 8'h3C, 8'h00, 1'b0, 40'h0000901050, 3, 3, 2};
    run_vec(v, "after_rst", lat);
    chk("after_rst.mem6_not_written", {56'd0, mem[6]}, 64'h00);
    chk("after_rst.mem7", {56'd0, mem[7]}, 64'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global guard so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
